// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults for the scoreboarded register file
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit tracking, busy count and stray writeback flag
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     stray_wb
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  cnt_nxt;
    logic             wr_hit;
    logic             iss_hit;

    assign wr_hit  = rst_n && wr_en && (wr_addr != ZERO_ADDR);
    assign iss_hit = rst_n && iss_en && !flush && (iss_addr != ZERO_ADDR);

    // Issue is applied after writeback so it wins on the same register.
    always_comb begin
        busy_nxt = busy;
        if (wr_hit)
            busy_nxt[wr_addr] = 1'b0;
        if (iss_hit)
            busy_nxt[iss_addr] = 1'b1;
        if (flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
            stray_wb <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (wr_hit && !busy[wr_addr])
                stray_wb <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_busy[k] = busy[a] &&
                            !(wr_hit && (wr_addr == a) && !(iss_hit && (iss_addr == a)));
    end
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write-through bypass and scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     stray_wb
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    // Writes are ignored while in reset, so the bypass is gated the same way.
    assign wr_ok = rst_n && wr_en && (wr_addr != ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] = (a == ZERO_ADDR)             ? '0 :
                                             (wr_ok && (wr_addr == a))    ? wr_data :
                                                                            mem[a];
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt),
        .stray_wb (stray_wb)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table-driven and model-driven bench for regfile_sb
module tb_regfile_sb;
    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  busy_cnt;
    logic        stray_wb;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt),
        .stray_wb (stray_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic        flush;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ecnt;
        logic        estray;
    } vec_t;

    typedef struct {
        logic [5:0] cnt;
        logic       stray;
        string      tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    logic        m_stray;

    function automatic vec_t mk(logic r, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic ie, logic [4:0] ia, logic fl, logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb,
                                logic [5:0] ec, logic es);
        vec_t v;
        v.rst_n = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.iss_en = ie; v.iss_addr = ia; v.flush = fl; v.ra0 = a0; v.ra1 = a1;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ecnt = ec; v.estray = es;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(logic r, logic we, logic [4:0] wa, logic [31:0] wd,
                         logic ie, logic [4:0] ia, logic fl, logic [4:0] a0, logic [4:0] a1);
        rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; flush = fl; rd_addr = {a1, a0};
    endtask

    task automatic pop_regs();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sbq.pop_front();
            chk({e.tag, "_cnt"}, {26'd0, busy_cnt}, {26'd0, e.cnt});
            chk({e.tag, "_stray"}, {31'd0, stray_wb}, {31'd0, e.stray});
        end
    endtask

    task automatic run_vec(vec_t v, string tag);
        exp_t e;
        @(negedge clk);
        apply(v.rst_n, v.wr_en, v.wr_addr, v.wr_data, v.iss_en, v.iss_addr, v.flush, v.ra0, v.ra1);
        #1;
        chk({tag, "_rd0"}, rd_data[31:0], v.e0);
        chk({tag, "_rd1"}, rd_data[63:32], v.e1);
        chk({tag, "_busy"}, {30'd0, rd_busy}, {30'd0, v.eb});
        e.cnt = v.ecnt; e.stray = v.estray; e.tag = tag;
        sbq.push_back(e);
        pop_regs();
    endtask

    task automatic model_cycle(int n);
        logic        we, ie, fl, wh, ih;
        logic [4:0]  wa, ia;
        logic [4:0]  ra [2];
        logic [31:0] wd, ed;
        logic        eb;
        int          cnt;
        exp_t        e;
        @(negedge clk);
        we = ($urandom_range(0, 1) == 1);
        ie = ($urandom_range(0, 1) == 1);
        fl = ($urandom_range(0, 15) == 0);
        wa = 5'($urandom_range(0, 7));
        ia = 5'($urandom_range(0, 7));
        wd = $urandom;
        ra[0] = 5'($urandom_range(0, 7));
        ra[1] = ($urandom_range(0, 3) == 0) ? ra[0] : 5'($urandom_range(0, 7));
        apply(1'b1, we, wa, wd, ie, ia, fl, ra[0], ra[1]);
        wh = we && (wa != 0);
        ih = ie && !fl && (ia != 0);
        #1;
        for (int k = 0; k < 2; k++) begin
            ed = (ra[k] == 0) ? 32'd0 : (wh && wa == ra[k]) ? wd : m_mem[ra[k]];
            eb = m_busy[ra[k]] && !(wh && wa == ra[k] && !(ih && ia == ra[k]));
            chk($sformatf("rnd%0d_rd%0d", n, k), rd_data[k*32 +: 32], ed);
            chk($sformatf("rnd%0d_busy%0d", n, k), {31'd0, rd_busy[k]}, {31'd0, eb});
        end
        if (wh && !m_busy[wa]) m_stray = 1'b1;
        if (wh) begin m_mem[wa] = wd; m_busy[wa] = 1'b0; end
        if (ih) m_busy[ia] = 1'b1;
        if (fl) m_busy = '0;
        cnt = 0;
        for (int i = 0; i < 32; i++) cnt += int'(m_busy[i]);
        e.cnt = 6'(cnt); e.stray = m_stray; e.tag = $sformatf("rnd%0d", n);
        sbq.push_back(e);
        pop_regs();
    endtask

    initial begin
        apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);

        //           rst we wa     wd            ie ia     fl ra0    ra1    e0            e1            eb     cnt  stray
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd5,  5'd5,  32'h0,        32'h0,        2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 1, 5'd5,  32'h1234,     0, 5'd0,  0, 5'd0,  5'd5,  32'h0,        32'h1234,     2'b00, 6'd0, 1));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd5,  5'd5,  32'h1234,     32'h1234,     2'b00, 6'd0, 1));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd5,  5'd5,  32'h1234,     32'h1234,     2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd5,  5'd5,  32'h0,        32'h0,        2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd7,  0, 5'd7,  5'd7,  32'h0,        32'h0,        2'b00, 6'd1, 0));
        tbl.push_back(mk(1, 1, 5'd7,  32'hAA,       1, 5'd7,  0, 5'd7,  5'd7,  32'hAA,       32'hAA,       2'b11, 6'd1, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd7,  5'd0,  32'hAA,       32'h0,        2'b01, 6'd1, 0));
        tbl.push_back(mk(1, 1, 5'd7,  32'h55,       0, 5'd0,  0, 5'd7,  5'd7,  32'h55,       32'h55,       2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd3,  5'd4,  32'h0,        32'h0,        2'b00, 6'd1, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd4,  0, 5'd3,  5'd4,  32'h0,        32'h0,        2'b01, 6'd2, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd9,  0, 5'd3,  5'd4,  32'h0,        32'h0,        2'b11, 6'd3, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd10, 1, 5'd9,  5'd10, 32'h0,        32'h0,        2'b01, 6'd0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd3,  5'd10, 32'h0,        32'h0,        2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd3,  5'd20, 32'h0,        32'h0,        2'b00, 6'd1, 0));
        tbl.push_back(mk(1, 1, 5'd3,  32'h77,       1, 5'd20, 0, 5'd3,  5'd20, 32'h77,       32'h0,        2'b00, 6'd1, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd3,  5'd20, 32'h77,       32'h0,        2'b10, 6'd1, 0));
        tbl.push_back(mk(1, 1, 5'd20, 32'h99,       0, 5'd0,  1, 5'd20, 5'd20, 32'h99,       32'h99,       2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 1, 5'd12, 32'hC,        0, 5'd0,  0, 5'd12, 5'd20, 32'hC,        32'h99,       2'b00, 6'd0, 1));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd12, 5'd12, 32'hC,        32'hC,        2'b00, 6'd0, 1));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd12, 5'd12, 32'hC,        32'hC,        2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        1, 5'd2,  0, 5'd2,  5'd12, 32'h0,        32'h0,        2'b00, 6'd1, 0));
        tbl.push_back(mk(0, 1, 5'd2,  32'hDEAD,     0, 5'd0,  0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd2,  5'd2,  32'h0,        32'h0,        2'b00, 6'd0, 0));
        tbl.push_back(mk(1, 1, 5'd2,  32'h42,       0, 5'd0,  0, 5'd2,  5'd2,  32'h42,       32'h42,       2'b00, 6'd0, 1));

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("row%0d", i));

        @(negedge clk);
        apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        @(posedge clk);
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_busy  = '0;
        m_stray = 1'b0;
        for (int n = 0; n < 150; n++)
            model_cycle(n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, read port count, legal 1..4.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state updates on rising edge.
  rst_n  in  1  reset, synchronous, active-low.
  rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
  rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
  rd_busy  out  NUM_RD  port k register has a pending producer.
  wr_en  in  1  writeback strobe.
  wr_addr  in  ADDR_W  writeback address.
  wr_data  in  DATA_W  writeback data.
  iss_en  in  1  issue strobe: reserve a destination.
  iss_addr  in  ADDR_W  destination being reserved.
  flush  in  1  clear all reservations.
  busy_cnt  out  ADDR_W+1  registered count of busy registers.
  stray_wb  out  1  sticky: writeback to a non-busy register seen.

Function
REQ-005 Register 0 SHALL read 0; writes and issues to address 0 SHALL be ignored; it SHALL never be busy.
REQ-006 Writes SHALL commit on the rising edge when wr_en=1 and wr_addr!=0.
REQ-007 Reads SHALL be combinational; when wr_en=1 and wr_addr==rd_addr[k]!=0, rd_data[k] SHALL equal wr_data in the same cycle (write-through bypass).
REQ-008 Busy bit of register r SHALL be set on an edge with iss_en=1, iss_addr=r, flush=0.
REQ-009 Busy bit of register r SHALL be cleared on an edge with wr_en=1, wr_addr=r, unless REQ-008 also applies to r that cycle (issue wins; data still written).
REQ-010 flush=1 SHALL clear every busy bit on that edge; a simultaneous iss_en SHALL be discarded; a simultaneous write SHALL still commit its data.
REQ-011 rd_busy[k] SHALL be the busy bit of rd_addr[k], forced to 0 when the same-cycle write to that address clears it per REQ-009; it SHALL NOT reflect a same-cycle issue.
REQ-012 busy_cnt SHALL equal the number of set busy bits after each edge (registered, one-cycle latency relative to inputs); range 0..2**ADDR_W-1.
REQ-013 stray_wb SHALL set on an edge with wr_en=1, wr_addr!=0, and the target busy bit 0 before the edge; it SHALL remain 1 until reset.
REQ-014 Read ports SHALL be independent; identical addresses on several ports SHALL return identical data and busy.
REQ-015 Issue and writeback to different addresses in one cycle SHALL both take effect.

Reset
REQ-016 On an edge with rst_n=0: all registers 0, all busy bits 0, busy_cnt 0, stray_wb 0; wr_en, iss_en and flush SHALL be ignored that edge.
REQ-017 Reset mid-operation SHALL discard all pending reservations; the first edge after deassertion SHALL behave as from a clean state.
REQ-018 Combinational outputs during reset SHALL reflect the cleared state after the first reset edge.

Structure
REQ-019 A shared package regfile_pkg SHALL hold default DATA_W, ADDR_W, NUM_RD and the zero-register address constant.
REQ-020 The busy-bit array, busy_cnt and stray_wb SHALL live in sub-module regfile_scoreboard; data storage and bypass remain in regfile_sb.
REQ-021 No negative-edge logic and no initial blocks SHALL be used; all state SHALL be initialised by reset.

Verification
REQ-022 Reset, then write r5=0x1234 and read r5 on port 1 in the same cycle -> rd_data[1]=0x1234 same cycle, and 0x1234 thereafter.
REQ-023 Write r0=0xFFFFFFFF with iss_en on r0 -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-024 Issue r7; next cycle issue r7 and write r7=0xAA simultaneously -> r7 reads 0xAA, r7 stays busy, busy_cnt=1, stray_wb=0.
REQ-025 Issue r3, r4, r9 on successive cycles -> busy_cnt 1,2,3; then flush with iss_en on r10 -> busy_cnt=0, all rd_busy=0.
REQ-026 Write r12 with no prior issue -> stray_wb=1 from next cycle, remaining 1 until rst_n=0 for one edge, then 0.
REQ-027 Issue r2, then assert rst_n=0 for one edge together with wr_en on r2 -> r2 reads 0, busy_cnt=0, stray_wb=0.
